rmii_tx_arbiter: RTL and testbench
==================================

Name: rmii_tx_arbiter

Overview:
Shares the single RMII transmit dibit path (2 bits/clk, valid-framed) between two frame sources, such as the ARP responder and the UDP frame builder.
- Grants are round-robin; each grant carries exactly one whole frame.
- Enforces the Ethernet inter-frame gap, a grant-start timeout and a maximum frame length.
- Output feeds the CRC/preamble appender ahead of the PHY.

Parameters:
IFG_CYCLES, 48, minimum cycles in GAP state after a frame (96 bit times at 2 bits/clk).
GRANT_TIMEOUT, 64, cycles a granted requester may take to raise valid before the grant is revoked.
MAX_FRAME_DIBITS, 6112, maximum dibits forwarded per frame (1528 bytes).

Ports:
clk  input  1  system clock (50 MHz RMII domain)
rst  input  1  synchronous, active-high reset
req  input  2  per-requester frame-ready request; bit k = requester k
gnt  output 2  one-hot-or-zero grant, registered
in0_v  input  1  requester 0 dibit valid
in0_d  input  2  requester 0 dibit
in1_v  input  1  requester 1 dibit valid
in1_d  input  2  requester 1 dibit
axiov  output 1  forwarded dibit valid, registered
axiod  output 2  forwarded dibit, registered
busy  output 1  state != IDLE
frame_done  output 1  1-cycle pulse when a frame ends normally (XMIT to GAP)
err_timeout  output 1  1-cycle pulse on grant timeout
err_overlong  output 1  1-cycle pulse on truncation

Behaviour:
- Reset: state=IDLE; gnt=0, axiov=0, axiod=0, all pulses 0; count=0; last_served=1, so requester 0 wins first.
- Counter: single shared counter of width clog2(max(MAX_FRAME_DIBITS, IFG_CYCLES, GRANT_TIMEOUT)+1). It is cleared on every state change.
- sel: the index of the current grant.
- Data path: each cycle, axiod <= in_sel_d. axiov <= in_sel_v when state is GRANT_WAIT or XMIT, else 0. Latency is 1 cycle.
- Non-granted in_v/in_d are ignored.
- IDLE:
  - If req[~last_served] is set, grant ~last_served; else if req[last_served] is set, grant it.
  - On a grant: gnt[sel]<=1, go to GRANT_WAIT.
  - No req: stay in IDLE.
- GRANT_WAIT:
  - in_sel_v=1: go to XMIT; this dibit is forwarded and counted as dibit 1.
  - Else if req[sel]=0: gnt<=0, go to IDLE with no error and last_served unchanged.
  - Else if count==GRANT_TIMEOUT-1: gnt<=0, last_served<=sel, err_timeout pulse, go to IDLE with no gap.
  - Otherwise count++.
- XMIT:
  - req is ignored here; the frame is bounded by in_sel_v alone.
  - in_sel_v=0: gnt<=0, last_served<=sel, frame_done pulse, go to GAP.
  - in_sel_v=1 with count==MAX_FRAME_DIBITS: this dibit is not forwarded (axiov<=0), err_overlong pulse, go to DRAIN. gnt stays high so the requester sees no change.
  - Otherwise count++.
- DRAIN: axiov=0. When in_sel_v=0: gnt<=0, last_served<=sel, go to GAP (no frame_done).
- GAP: count++ each cycle; on count==IFG_CYCLES-1 go to IDLE.
  - axiov is low for at least IFG_CYCLES+2 cycles between frames, with exactly IFG_CYCLES+2 when the requester raises in_v in the first gnt cycle.
- Simultaneous req while busy: held requests are evaluated only in IDLE, so a request arriving during XMIT/GAP waits.
- Reset mid-frame: next cycle axiov=0 and gnt=0; the aborted frame is not resumed.
- Single-requester: back-to-back frames from the same requester are allowed when the other req=0.

Test Plan:
- Reset, then req=01 and requester 0 sends 8 dibits 3,2,1,0,3,2,1,0 after gnt -> gnt=01 one cycle after req; axiov high for exactly 8 cycles with same data delayed 1 cycle; frame_done pulses once; busy returns low after 48 GAP cycles plus exit.
- Reset, req=11 held, both send 4-dibit frames -> order is requester 0, 1, 0, 1; gnt never 11; each axiov fall-to-rise gap is ≥50 cycles.
- req=10, requester 1 never raises in1_v -> gnt=10 for 64 cycles, then gnt=00, err_timeout pulses once, axiov stays 0, no GAP delay before the next grant.
- MAX_FRAME_DIBITS=16, requester 0 sends 20 dibits -> axiov high 16 cycles; err_overlong on the 17th; gnt held until in0_v falls; no frame_done; GAP follows.
- rst asserted for 1 cycle at dibit 5 of a 10-dibit frame -> axiov=0 and gnt=00 the cycle after; the subsequent req=01 is granted and its frame forwarded normally.
- req[0] dropped during GRANT_WAIT before in0_v -> gnt=00, no error pulse, requester 0 still has priority on the next simultaneous req=11.

Source files
------------

// File: rtl/rmii_tx_arbiter.sv
// Purpose: round-robin share of one RMII TX dibit stream between two frame sources, one whole frame per grant.
// Latency: forwarded dibit appears one cycle after the granted source presents it; grant is one cycle after request.
// Backpressure: none on the dibit path; sources hold off via req/gnt, with grant timeout, length cap and IFG enforcement.
module rmii_tx_arbiter #(
    parameter int IFG_CYCLES       = 48,
    parameter int GRANT_TIMEOUT    = 64,
    parameter int MAX_FRAME_DIBITS = 6112
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       in0_v,
    input  logic [1:0] in0_d,
    input  logic       in1_v,
    input  logic [1:0] in1_d,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       frame_done,
    output logic       err_timeout,
    output logic       err_overlong
);

    localparam int MAXV1 = (MAX_FRAME_DIBITS > IFG_CYCLES) ? MAX_FRAME_DIBITS : IFG_CYCLES;
    localparam int MAXV  = (MAXV1 > GRANT_TIMEOUT) ? MAXV1 : GRANT_TIMEOUT;
    localparam int CW    = $clog2(MAXV + 1);

    localparam logic [CW-1:0] TMO_LAST   = CW'(GRANT_TIMEOUT - 1);
    localparam logic [CW-1:0] IFG_LAST   = CW'(IFG_CYCLES - 1);
    localparam logic [CW-1:0] FRAME_FULL = CW'(MAX_FRAME_DIBITS);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_WAIT,
        XMIT,
        DRAIN,
        GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          sel, sel_nxt;
    logic          last_served, last_served_nxt;
    logic [1:0]    gnt_nxt;
    logic          axiov_nxt;
    logic          frame_done_nxt, err_timeout_nxt, err_overlong_nxt;

    logic          in_sel_v;
    logic [1:0]    in_sel_d;
    logic          pick;

    // Mux the granted source; the other source is ignored entirely.
    always_comb begin
        in_sel_v = sel ? in1_v : in0_v;
        in_sel_d = sel ? in1_d : in0_d;
        // Prefer the requester that was not served last.
        pick     = req[~last_served] ? ~last_served : last_served;
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_nxt        = state;
        count_nxt        = count;
        sel_nxt          = sel;
        last_served_nxt  = last_served;
        gnt_nxt          = gnt;
        axiov_nxt        = 1'b0;
        frame_done_nxt   = 1'b0;
        err_timeout_nxt  = 1'b0;
        err_overlong_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    sel_nxt   = pick;
                    gnt_nxt   = {pick, ~pick};
                    count_nxt = '0;
                    state_nxt = GRANT_WAIT;
                end
            end
            GRANT_WAIT: begin
                axiov_nxt = in_sel_v;
                if (in_sel_v) begin
                    // First dibit is forwarded now and counts as dibit 1.
                    count_nxt = CW'(1);
                    state_nxt = XMIT;
                end else if (!req[sel]) begin
                    // Requester withdrew: no error, priority untouched.
                    gnt_nxt   = 2'b00;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else if (count == TMO_LAST) begin
                    gnt_nxt         = 2'b00;
                    last_served_nxt = sel;
                    err_timeout_nxt = 1'b1;
                    count_nxt       = '0;
                    state_nxt       = IDLE;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            XMIT: begin
                if (!in_sel_v) begin
                    gnt_nxt         = 2'b00;
                    last_served_nxt = sel;
                    frame_done_nxt  = 1'b1;
                    count_nxt       = '0;
                    state_nxt       = GAP;
                end else if (count == FRAME_FULL) begin
                    // Truncate: keep gnt high so the source keeps streaming into DRAIN.
                    err_overlong_nxt = 1'b1;
                    count_nxt        = '0;
                    state_nxt        = DRAIN;
                end else begin
                    axiov_nxt = 1'b1;
                    count_nxt = count + 1'b1;
                end
            end
            DRAIN: begin
                if (!in_sel_v) begin
                    gnt_nxt         = 2'b00;
                    last_served_nxt = sel;
                    count_nxt       = '0;
                    state_nxt       = GAP;
                end
            end
            GAP: begin
                if (count == IFG_LAST) begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            default: begin
                gnt_nxt   = 2'b00;
                count_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            sel          <= 1'b0;
            last_served  <= 1'b1;
            gnt          <= 2'b00;
            axiov        <= 1'b0;
            axiod        <= 2'b00;
            frame_done   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overlong <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            sel          <= sel_nxt;
            last_served  <= last_served_nxt;
            gnt          <= gnt_nxt;
            axiov        <= axiov_nxt;
            axiod        <= in_sel_d;
            frame_done   <= frame_done_nxt;
            err_timeout  <= err_timeout_nxt;
            err_overlong <= err_overlong_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// Purpose: self-checking bench for rmii_tx_arbiter with a dibit scoreboard.
// Latency: checks 1-cycle data path, 1-cycle grant, IFG and timeout timing.
// Backpressure: sources respond to gnt in the first granted cycle.
module tb_rmii_tx_arbiter;

    localparam int IFG  = 48;
    localparam int TMO  = 64;
    localparam int MAXF = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       in0_v, in1_v;
    logic [1:0] in0_d, in1_d;
    logic       axiov;
    logic [1:0] axiod;
    logic       busy, frame_done, err_timeout, err_overlong;

    always #5 clk = ~clk;

    rmii_tx_arbiter #(
        .IFG_CYCLES      (IFG),
        .GRANT_TIMEOUT   (TMO),
        .MAX_FRAME_DIBITS(MAXF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .in0_v       (in0_v),
        .in0_d       (in0_d),
        .in1_v       (in1_v),
        .in1_d       (in1_d),
        .axiov       (axiov),
        .axiod       (axiod),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .err_overlong(err_overlong)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] sb[$];
    int         n_axiov  = 0;
    int         n_done   = 0;
    int         n_tmo    = 0;
    int         n_ovl    = 0;
    bit         gnt_both = 1'b0;
    bit         seen_high = 1'b0;
    int         low_run  = 0;
    int         gaps[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and observe outputs 1 time unit after the edge.
    task automatic step();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (gnt == 2'b11) gnt_both = 1'b1;
        if (frame_done) n_done++;
        if (err_timeout) n_tmo++;
        if (err_overlong) n_ovl++;
        if (axiov) begin
            n_axiov++;
            if (sb.size() == 0) chk("sb_extra_dibit", 1, 0);
            else chk("axiod", axiod, sb.pop_front());
            if (seen_high && low_run > 0) gaps.push_back(low_run);
            seen_high = 1'b1;
            low_run   = 0;
        end else begin
            low_run++;
        end
        if (r) begin
            seen_high = 1'b0;
            low_run   = 0;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 2'b00;
        in0_v = 1'b0;
        in1_v = 1'b0;
        in0_d = 2'b00;
        in1_d = 2'b00;
        sb.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input int k, input logic v, input logic [1:0] d);
        if (k == 0) begin
            in0_v = v;
            in0_d = d;
        end else begin
            in1_v = v;
            in1_d = d;
        end
    endtask

    function automatic logic [1:0] pat(input int seed, input int i);
        return 2'((seed + 3 * i) & 3);
    endfunction

    // Stream n dibits from source k, expecting all of them forwarded.
    task automatic send(input int k, input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            drive(k, 1'b1, pat(seed, i));
            sb.push_back(pat(seed, i));
            step();
        end
        drive(k, 1'b0, 2'b00);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0, d0, t0, o0, g0;
        bit held;

        // Reset values and a single 8-dibit frame from requester 0.
        do_reset();
        chk("rst_gnt", gnt, 0);
        chk("rst_axiov", axiov, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {frame_done, err_timeout, err_overlong}, 0);
        a0 = n_axiov; d0 = n_done;
        req = 2'b01;
        step();
        chk("t1_gnt_latency", gnt, 2'b01);
        send(0, 8, 3);
        req = 2'b00;
        step();
        chk("t1_frame_done", frame_done, 1);
        wait_idle(n);
        chk("t1_gap_to_idle", n, IFG);
        chk("t1_axiov_cycles", n_axiov - a0, 8);
        chk("t1_done_count", n_done - d0, 1);
        chk("t1_sb_empty", sb.size(), 0);

        // Both requesting: strict alternation with exact IFG spacing.
        do_reset();
        g0 = gaps.size();
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            n = 0;
            while (gnt == 2'b00 && n < 300) begin
                step();
                n++;
            end
            chk("t2_order", gnt, (f % 2 == 0) ? 2'b01 : 2'b10);
            send(f % 2, 4, f + 1);
            if (f == 3) req = 2'b00;
            step();
        end
        wait_idle(n);
        chk("t2_gap_count", gaps.size() - g0, 3);
        for (int i = g0; i < gaps.size(); i++) chk("t2_gap_len", gaps[i], IFG + 2);
        chk("t2_sb_empty", sb.size(), 0);

        // Grant timeout on requester 1, then immediate re-grant.
        do_reset();
        a0 = n_axiov; t0 = n_tmo;
        req = 2'b10;
        step();
        n = 0;
        while (gnt == 2'b10 && n < 300) begin
            n++;
            step();
        end
        chk("t3_gnt_len", n, TMO);
        chk("t3_err_timeout", err_timeout, 1);
        chk("t3_revoked", gnt, 0);
        step();
        chk("t3_regrant_no_gap", gnt, 2'b10);
        chk("t3_tmo_count", n_tmo - t0, 1);
        req = 2'b00;
        step();
        chk("t3_drop_gnt", gnt, 0);
        chk("t3_drop_no_err", err_timeout, 0);
        chk("t3_axiov_quiet", n_axiov - a0, 0);

        // Overlong frame: 20 dibits offered, 16 forwarded.
        do_reset();
        a0 = n_axiov; d0 = n_done; o0 = n_ovl;
        held = 1'b1;
        req = 2'b01;
        step();
        chk("t4_gnt", gnt, 2'b01);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'b1, pat(2, i));
            if (i < MAXF) sb.push_back(pat(2, i));
            step();
            if (gnt != 2'b01) held = 1'b0;
            if (i == MAXF) chk("t4_ovl_pulse", err_overlong, 1);
        end
        chk("t4_gnt_held", held, 1);
        drive(0, 1'b0, 2'b00);
        req = 2'b00;
        step();
        chk("t4_gnt_release", gnt, 0);
        wait_idle(n);
        chk("t4_gap_to_idle", n, IFG);
        chk("t4_axiov_cycles", n_axiov - a0, MAXF);
        chk("t4_ovl_count", n_ovl - o0, 1);
        chk("t4_no_done", n_done - d0, 0);

        // Reset in the middle of a frame, then a clean frame.
        do_reset();
        a0 = n_axiov; d0 = n_done;
        req = 2'b01;
        step();
        chk("t5_gnt", gnt, 2'b01);
        send(0, 4, 1);
        rst = 1'b1;
        drive(0, 1'b1, pat(1, 4));
        step();
        rst = 1'b0;
        drive(0, 1'b0, 2'b00);
        chk("t5_axiov_cleared", axiov, 0);
        chk("t5_gnt_cleared", gnt, 0);
        step();
        chk("t5_regrant", gnt, 2'b01);
        send(0, 6, 0);
        req = 2'b00;
        step();
        chk("t5_frame_done", frame_done, 1);
        wait_idle(n);
        chk("t5_axiov_cycles", n_axiov - a0, 10);
        chk("t5_done_count", n_done - d0, 1);

        // Withdrawn request keeps requester 0 first in line.
        do_reset();
        t0 = n_tmo;
        req = 2'b01;
        step();
        chk("t6_gnt", gnt, 2'b01);
        req = 2'b00;
        step();
        chk("t6_withdraw", gnt, 0);
        chk("t6_no_err", n_tmo - t0, 0);
        req = 2'b11;
        step();
        chk("t6_priority", gnt, 2'b01);
        req = 2'b00;
        step();
        step();

        chk("no_dual_grant", gnt_both, 0);
        chk("sb_final_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
